// File: rtl/mmio_output_bank_if.sv
// CPU data bus bundle for mmio_output_bank: active-low chip enable, write strobe,
// word address, write data and registered read data.
interface mmio_output_bank_if;
  logic        nce;
  logic        we;
  logic [10:0] addr;
  logic [31:0] data;
  logic [31:0] rdata;

  modport master (output nce, we, addr, data, input rdata);
  modport slave  (input nce, we, addr, data, output rdata);
endinterface

// File: rtl/mmio_output_bank.sv
// Memory-mapped output bank: per-port DATA/SET/CLR/TGL aliases, readback and a
// self-timed one-shot pulse engine with programmable length.
module mmio_output_bank #(
  parameter int NUM_PORTS     = 4,
  parameter int PORT_WIDTH    = 10,
  parameter int CNT_WIDTH     = 16,
  parameter int PULSE_DEFAULT = 1000
) (
  input  logic                            clk,
  input  logic                            rst,
  mmio_output_bank_if.slave               bus,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] ports,
  output logic [NUM_PORTS-1:0]            busy
);
  typedef logic [PORT_WIDTH-1:0] pval_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;

  pval_t       val_q  [NUM_PORTS];
  pval_t       val_d  [NUM_PORTS];
  pval_t       mask_q [NUM_PORTS];
  pval_t       mask_d [NUM_PORTS];
  cnt_t        cnt_q  [NUM_PORTS];
  cnt_t        cnt_d  [NUM_PORTS];
  cnt_t        plen_q [NUM_PORTS];
  cnt_t        plen_d [NUM_PORTS];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  logic [7:0] idx;
  logic [2:0] off;
  logic       wr;
  logic       rd;
  pval_t      wdat;
  cnt_t       wlen;

  assign idx  = bus.addr[10:3];
  assign off  = bus.addr[2:0];
  assign wr   = !bus.nce && bus.we;
  assign rd   = !bus.nce && !bus.we;
  assign wdat = bus.data[PORT_WIDTH-1:0];
  assign wlen = bus.data[CNT_WIDTH-1:0];

  always_comb begin
    logic hit;
    hit     = 1'b0;
    rdata_d = rd ? 32'd0 : rdata_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      val_d[i]  = val_q[i];
      mask_d[i] = mask_q[i];
      cnt_d[i]  = cnt_q[i];
      plen_d[i] = plen_q[i];
      hit       = wr && (idx == 8'(i));

      // A re-arm takes priority over expiry; a zero mask only matters while busy.
      if (hit && off == 3'd4 && (wdat != '0 || cnt_q[i] != '0)) begin
        val_d[i]  = val_q[i] | wdat;
        mask_d[i] = mask_q[i] | wdat;
        cnt_d[i]  = (plen_q[i] == '0) ? cnt_t'(1) : plen_q[i];
      end else if (cnt_q[i] == cnt_t'(1)) begin
        val_d[i]  = val_q[i] & ~mask_q[i];
        mask_d[i] = '0;
        cnt_d[i]  = '0;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i]  = cnt_q[i] - cnt_t'(1);
      end

      // Bus edits land on top of any expiry clear from the same edge.
      if (hit) begin
        case (off)
          3'd0:    val_d[i]  = wdat;
          3'd1:    val_d[i]  = val_d[i] | wdat;
          3'd2:    val_d[i]  = val_d[i] & ~wdat;
          3'd3:    val_d[i]  = val_d[i] ^ wdat;
          3'd5:    plen_d[i] = wlen;
          default: ;
        endcase
      end

      if (rd && idx == 8'(i)) begin
        case (off)
          3'd0:    rdata_d = 32'(val_q[i]);
          3'd4:    rdata_d = 32'(mask_q[i]);
          3'd5:    rdata_d = 32'(plen_q[i]);
          default: rdata_d = 32'd0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        val_q[i]  <= '0;
        mask_q[i] <= '0;
        cnt_q[i]  <= '0;
        plen_q[i] <= cnt_t'(PULSE_DEFAULT);
      end
      rdata_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        val_q[i]  <= val_d[i];
        mask_q[i] <= mask_d[i];
        cnt_q[i]  <= cnt_d[i];
        plen_q[i] <= plen_d[i];
      end
      rdata_q <= rdata_d;
    end
  end

  assign bus.rdata = rdata_q;

  always_comb begin
    ports = '0;
    busy  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      ports[i*PORT_WIDTH +: PORT_WIDTH] = val_q[i];
      busy[i]                           = (cnt_q[i] != '0);
    end
  end
endmodule

// File: tb/tb_mmio_output_bank.sv
// Directed bench for mmio_output_bank with default parameters (4 ports x 10 bits).
module tb_mmio_output_bank;
  logic        clk;
  logic        rst;
  logic [39:0] ports;
  logic [3:0]  busy;
  int          tests;
  int          failed;

  mmio_output_bank_if bus ();

  mmio_output_bank dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .ports (ports),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic n, input logic w, input logic [7:0] idx,
                        input logic [2:0] off, input logic [31:0] d);
    @(negedge clk);
    bus.nce  = n;
    bus.we   = w;
    bus.addr = {idx, off};
    bus.data = d;
    @(posedge clk);
    #1;
    bus.nce  = 1'b1;
    bus.we   = 1'b0;
  endtask

  task automatic wr(input logic [7:0] idx, input logic [2:0] off, input logic [31:0] d);
    access(1'b0, 1'b1, idx, off, d);
  endtask

  task automatic rd(input logic [7:0] idx, input logic [2:0] off);
    access(1'b0, 1'b0, idx, off, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] pv(input logic [9:0] p0, input logic [9:0] p1,
                                     input logic [9:0] p2, input logic [9:0] p3);
    return {p3, p2, p1, p0};
  endfunction

  initial begin
    tests    = 0;
    failed   = 0;
    rst      = 1'b1;
    bus.nce  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = '0;
    bus.data = '0;
    repeat (3) tick();
    @(negedge clk);
    rst = 1'b0;

    check("reset_ports", ports, 40'd0);
    check("reset_busy", busy, 4'd0);
    check("reset_rdata", bus.rdata, 32'd0);
    rd(8'd0, 3'd5);
    check("plen_default", bus.rdata, 32'd1000);

    // 1: legacy address 0
    wr(8'd0, 3'd0, 32'hFFFF_FFFF);
    check("p0_data_write", ports, pv(10'h3FF, 10'h0, 10'h0, 10'h0));
    rd(8'd0, 3'd0);
    check("p0_data_read", bus.rdata, 32'h3FF);

    // 2: set/clr/tgl aliases
    wr(8'd1, 3'd0, 32'h0F0);
    wr(8'd1, 3'd1, 32'h003);
    check("p1_set", ports[19:10], 10'h0F3);
    wr(8'd1, 3'd2, 32'h010);
    check("p1_clr", ports[19:10], 10'h0E3);
    wr(8'd1, 3'd3, 32'h101);
    check("p1_tgl", ports, pv(10'h3FF, 10'h1E2, 10'h0, 10'h0));
    rd(8'd1, 3'd0);
    check("p1_read", bus.rdata, 32'h1E2);
    rd(8'd1, 3'd1);
    check("p1_read_set", bus.rdata, 32'd0);
    rd(8'd1, 3'd0);
    rd(8'd1, 3'd2);
    check("p1_read_clr", bus.rdata, 32'd0);
    rd(8'd1, 3'd0);
    rd(8'd1, 3'd3);
    check("p1_read_tgl", bus.rdata, 32'd0);
    rd(8'd1, 3'd0);
    rd(8'd1, 3'd6);
    check("p1_read_rsvd", bus.rdata, 32'd0);

    // 3: 5-cycle pulse on port 2
    wr(8'd2, 3'd5, 32'd5);
    wr(8'd2, 3'd4, 32'h00C);
    check("p3_pulse_c0", ports, pv(10'h3FF, 10'h1E2, 10'h00C, 10'h0));
    check("p3_busy_c0", busy, 4'b0100);
    for (int k = 1; k < 5; k++) begin
      tick();
      check($sformatf("p3_pulse_c%0d", k), ports[29:20], 10'h00C);
      check($sformatf("p3_busy_c%0d", k), busy, 4'b0100);
    end
    tick();
    check("p3_pulse_end", ports, pv(10'h3FF, 10'h1E2, 10'h0, 10'h0));
    check("p3_busy_end", busy, 4'b0000);

    // 4: re-arm, then zero PLEN
    wr(8'd2, 3'd5, 32'd8);
    wr(8'd2, 3'd4, 32'h001);
    tick();
    tick();
    wr(8'd2, 3'd4, 32'h002);
    check("p4_rearm", ports[29:20], 10'h003);
    repeat (7) tick();
    check("p4_rearm_last", ports[29:20], 10'h003);
    check("p4_rearm_busy", busy, 4'b0100);
    tick();
    check("p4_rearm_end", ports[29:20], 10'h000);
    check("p4_rearm_idle", busy, 4'b0000);
    wr(8'd2, 3'd5, 32'd0);
    wr(8'd2, 3'd4, 32'h001);
    check("p4_plen0_on", ports[29:20], 10'h001);
    check("p4_plen0_busy", busy, 4'b0100);
    tick();
    check("p4_plen0_off", ports[29:20], 10'h000);
    check("p4_plen0_idle", busy, 4'b0000);
    wr(8'd2, 3'd4, 32'h000);
    check("p4_zero_mask", busy, 4'b0000);

    // 5: SET on expiry edge, then reset mid-pulse
    wr(8'd3, 3'd5, 32'd3);
    wr(8'd3, 3'd4, 32'h001);
    tick();
    tick();
    check("p5_before_exp", ports[39:30], 10'h001);
    wr(8'd3, 3'd1, 32'h001);
    check("p5_set_on_exp", ports[39:30], 10'h001);
    check("p5_busy_exp", busy, 4'b0000);
    wr(8'd3, 3'd4, 32'h002);
    rd(8'd3, 3'd4);
    check("p5_mask_read", bus.rdata, 32'h002);
    check("p5_mid_pulse", ports[39:30], 10'h003);
    @(negedge clk);
    rst = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
    check("p5_rst_ports", ports, 40'd0);
    check("p5_rst_busy", busy, 4'd0);
    check("p5_rst_rdata", bus.rdata, 32'd0);
    rd(8'd3, 3'd5);
    check("p5_rst_plen", bus.rdata, 32'd1000);

    // 6: out-of-range port and deselected cycles
    wr(8'd4, 3'd0, 32'h3FF);
    wr(8'd4, 3'd1, 32'h3FF);
    check("p6_oor_write", ports, 40'd0);
    wr(8'd0, 3'd0, 32'h155);
    rd(8'd0, 3'd0);
    check("p6_read_p0", bus.rdata, 32'h155);
    access(1'b1, 1'b0, 8'd1, 3'd5, 32'd0);
    check("p6_nce_rd_hold", bus.rdata, 32'h155);
    access(1'b1, 1'b1, 8'd0, 3'd0, 32'h2AA);
    check("p6_nce_wr", ports, pv(10'h155, 10'h0, 10'h0, 10'h0));
    check("p6_nce_wr_hold", bus.rdata, 32'h155);
    rd(8'd4, 3'd5);
    check("p6_oor_read", bus.rdata, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
